// File: rtl/elev_pkg.sv
// Shared state codes and sizing helper for the elevator controller slice.
package elev_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_UP   = 3'd1,
    ST_GOING_UP   = 3'd2,
    ST_START_DOWN = 3'd3,
    ST_GOING_DOWN = 3'd4,
    ST_DOOR_OPEN  = 3'd5
  } state_t;

  // Width of a floor index; never below one bit.
  function automatic int floor_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elev_req_if.sv
// Request-tracker bus between the controller FSM and the request register.
// Contract: call bits latch on the next edge; a clear for the same floor on that edge wins over the call.
interface elev_req_if #(
  parameter int N_FLOORS = 8,
  parameter int FW       = 3
) ();

  logic [N_FLOORS-1:0] call;
  logic                clear_en;
  logic [FW-1:0]       clear_idx;
  logic [FW-1:0]       cur_floor;
  logic [N_FLOORS-1:0] pending;
  logic                here;
  logic                above;
  logic                below;

  modport master (
    output call, clear_en, clear_idx, cur_floor,
    input  pending, here, above, below
  );

  modport slave (
    input  call, clear_en, clear_idx, cur_floor,
    output pending, here, above, below
  );

endinterface

// File: rtl/elev_req_tracker.sv
// Outstanding-request register plus the here/above/below search relative to the current floor.
module elev_req_tracker import elev_pkg::*; #(
  parameter int N_FLOORS = 8
) (
  input logic       clk,
  input logic       reset,
  elev_req_if.slave bus
);

  logic [N_FLOORS-1:0] pend_q;
  logic [N_FLOORS-1:0] clear_mask;
  logic                above_c;
  logic                below_c;

  always_comb begin
    clear_mask = '0;
    if (bus.clear_en) clear_mask[bus.clear_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= (pend_q | bus.call) & ~clear_mask;
  end

  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pend_q[i] && (i > int'(bus.cur_floor))) above_c = 1'b1;
      if (pend_q[i] && (i < int'(bus.cur_floor))) below_c = 1'b1;
    end
  end

  assign bus.pending = pend_q;
  assign bus.here    = pend_q[bus.cur_floor];
  assign bus.above   = above_c;
  assign bus.below   = below_c;

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator controller: travel/door FSM with dwell counter; requests are held in elev_req_tracker.
module elevator_ctrl import elev_pkg::*; #(
  parameter int N_FLOORS    = 8,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_FLOORS-1:0]         call_req,
  input  logic [N_FLOORS-1:0]         at_floor,
  input  logic                        doors_closed,
  output logic [2:0]                  state,
  output logic [$clog2(N_FLOORS)-1:0] cur_floor,
  output logic [N_FLOORS-1:0]         pending,
  output logic                        motor_on,
  output logic                        motor_direction,
  output logic                        fan_on,
  output logic                        door_open
);

  localparam int FW = floor_w(N_FLOORS);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR  = FW'(N_FLOORS - 1);

  state_t        st;
  state_t        resume;
  logic [FW-1:0] floor_q;
  logic [DW-1:0] dwell;
  logic [FW-1:0] at_idx;
  logic          at_onehot;
  logic          stop_going;
  logic          enter_door;
  logic          restart;

  elev_req_if #(.N_FLOORS(N_FLOORS), .FW(FW)) req ();

  elev_req_tracker #(.N_FLOORS(N_FLOORS)) u_req (
    .clk   (clk),
    .reset (reset),
    .bus   (req)
  );

  always_comb begin
    at_idx = '0;
    for (int i = 0; i < N_FLOORS; i++)
      if (at_floor[i]) at_idx = FW'(i);
  end

  assign at_onehot = (at_floor != '0) && ((at_floor & (at_floor - N_FLOORS'(1))) == '0);

  // End floors stop the car even when nobody asked for them.
  assign stop_going = at_onehot &&
    (((st == ST_GOING_UP)   && (req.pending[at_idx] || (at_idx == TOP_FLOOR))) ||
     ((st == ST_GOING_DOWN) && (req.pending[at_idx] || (at_idx == '0))));
  assign enter_door = stop_going || ((st == ST_IDLE) && req.here);
  assign restart    = (st == ST_DOOR_OPEN) && call_req[floor_q];

  assign req.call      = call_req;
  assign req.cur_floor = floor_q;
  assign req.clear_en  = enter_door || (st == ST_DOOR_OPEN);
  assign req.clear_idx = stop_going ? at_idx : floor_q;

  // Keep going the way we were heading while there is work that way.
  always_comb begin
    resume = ST_IDLE;
    if (motor_direction) begin
      if (req.above)      resume = ST_START_UP;
      else if (req.below) resume = ST_START_DOWN;
    end else begin
      if (req.below)      resume = ST_START_DOWN;
      else if (req.above) resume = ST_START_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= ST_IDLE;
      floor_q         <= '0;
      dwell           <= '0;
      motor_on        <= 1'b0;
      motor_direction <= 1'b1;
      fan_on          <= 1'b0;
      door_open       <= 1'b0;
    end else begin
      if (at_onehot) floor_q <= at_idx;
      motor_on  <= 1'b0;
      door_open <= 1'b0;
      fan_on    <= 1'b1;
      case (st)
        ST_IDLE: begin
          if (enter_door) begin
            st        <= ST_DOOR_OPEN;
            door_open <= 1'b1;
            dwell     <= '0;
          end else begin
            st     <= resume;
            fan_on <= (resume != ST_IDLE);
            if (resume == ST_START_UP)   motor_direction <= 1'b1;
            if (resume == ST_START_DOWN) motor_direction <= 1'b0;
          end
        end
        ST_START_UP, ST_START_DOWN: begin
          if (doors_closed) begin
            st       <= (st == ST_START_UP) ? ST_GOING_UP : ST_GOING_DOWN;
            motor_on <= 1'b1;
          end
        end
        ST_GOING_UP, ST_GOING_DOWN: begin
          if (enter_door) begin
            st        <= ST_DOOR_OPEN;
            door_open <= 1'b1;
            dwell     <= '0;
          end else begin
            motor_on <= 1'b1;
          end
        end
        ST_DOOR_OPEN: begin
          if (restart) begin
            dwell     <= '0;
            door_open <= 1'b1;
          end else if (dwell == DWELL_LAST) begin
            st     <= resume;
            fan_on <= (resume != ST_IDLE);
            if (resume == ST_START_UP)   motor_direction <= 1'b1;
            if (resume == ST_START_DOWN) motor_direction <= 1'b0;
          end else begin
            dwell     <= dwell + DW'(1);
            door_open <= 1'b1;
          end
        end
        default: begin
          st     <= ST_IDLE;
          fan_on <= 1'b0;
        end
      endcase
    end
  end

  assign state     = st;
  assign cur_floor = floor_q;
  assign pending   = req.pending;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: car/shaft plant, behavioural reference model, directed scenarios and random traffic.
module tb_elevator_ctrl;

  localparam int NF = 8;
  localparam int DC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [NF-1:0] call_req = '0;
  logic [NF-1:0] at_floor = 8'h01;
  logic          doors_closed = 1'b1;
  logic [2:0]    state;
  logic [2:0]    cur_floor;
  logic [NF-1:0] pending;
  logic          motor_on, motor_direction, fan_on, door_open;

  elevator_ctrl #(.N_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .at_floor(at_floor),
    .doors_closed(doors_closed), .state(state), .cur_floor(cur_floor), .pending(pending),
    .motor_on(motor_on), .motor_direction(motor_direction), .fan_on(fan_on), .door_open(door_open)
  );

  logic        s2_reset = 1'b1;
  logic [1:0]  s2_call = '0, s2_at = 2'b01;
  logic        s2_dc = 1'b1;
  logic [2:0]  s2_state;
  logic [0:0]  s2_floor;
  logic [1:0]  s2_pend;
  logic        s2_motor, s2_dir, s2_fan, s2_door;

  elevator_ctrl #(.N_FLOORS(2), .DOOR_CYCLES(4)) dut2 (
    .clk(clk), .reset(s2_reset), .call_req(s2_call), .at_floor(s2_at),
    .doors_closed(s2_dc), .state(s2_state), .cur_floor(s2_floor), .pending(s2_pend),
    .motor_on(s2_motor), .motor_direction(s2_dir), .fan_on(s2_fan), .door_open(s2_door)
  );

  logic        s16_reset = 1'b1;
  logic [15:0] s16_call = '0, s16_at = 16'h0001;
  logic        s16_dc = 1'b1;
  logic [2:0]  s16_state;
  logic [3:0]  s16_floor;
  logic [15:0] s16_pend;
  logic        s16_motor, s16_dir, s16_fan, s16_door;

  elevator_ctrl #(.N_FLOORS(16), .DOOR_CYCLES(4)) dut16 (
    .clk(clk), .reset(s16_reset), .call_req(s16_call), .at_floor(s16_at),
    .doors_closed(s16_dc), .state(s16_state), .cur_floor(s16_floor), .pending(s16_pend),
    .motor_on(s16_motor), .motor_direction(s16_dir), .fan_on(s16_fan), .door_open(s16_door)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (state codes as published for the controller).
  int            m_state, m_floor, m_left;
  bit            m_dir, m_motor, m_fan, m_door;
  logic [NF-1:0] m_pend;

  int pos, travel, hop = 3;
  int door_cnt;
  logic [2:0] prev_state;
  logic [2:0] stops_q[$];
  logic [2:0] exp_q[$];

  function automatic int pick_dir(input bit dir, input bit up, input bit down);
    if (dir) return up ? 1 : (down ? 3 : 0);
    return down ? 3 : (up ? 1 : 0);
  endfunction

  task automatic model_step(input logic rst, input logic [NF-1:0] c, input logic [NF-1:0] at,
                            input logic dc);
    int nstate, stop_floor, k, n_ones;
    bit up_req, down_req;
    if (rst) begin
      m_state = 0; m_floor = 0; m_pend = '0; m_dir = 1'b1;
      m_motor = 1'b0; m_fan = 1'b0; m_door = 1'b0; m_left = 0;
      return;
    end
    n_ones = $countones(at);
    k = -1;
    for (int i = 0; i < NF; i++) if (at[i]) k = i;
    up_req = 1'b0; down_req = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_floor) up_req = 1'b1;
      if (m_pend[i] && i < m_floor) down_req = 1'b1;
    end
    nstate = m_state;
    stop_floor = -1;
    case (m_state)
      0: if (m_pend[m_floor]) stop_floor = m_floor; else nstate = pick_dir(m_dir, up_req, down_req);
      1: if (dc) nstate = 2;
      2: if (n_ones == 1 && (m_pend[k] || k == NF - 1)) stop_floor = k;
      3: if (dc) nstate = 4;
      4: if (n_ones == 1 && (m_pend[k] || k == 0)) stop_floor = k;
      5: begin
        if (c[m_floor]) m_left = DC;
        else if (m_left == 1) nstate = pick_dir(m_dir, up_req, down_req);
        else m_left--;
      end
      default: nstate = 0;
    endcase
    m_pend = m_pend | c;
    if (m_state == 5) m_pend[m_floor] = 1'b0;
    if (stop_floor >= 0) begin
      nstate = 5;
      m_pend[stop_floor] = 1'b0;
      m_left = DC;
    end
    if (n_ones == 1) m_floor = k;
    if (nstate == 1) m_dir = 1'b1;
    else if (nstate == 3) m_dir = 1'b0;
    m_motor = (nstate == 2 || nstate == 4);
    m_door  = (nstate == 5);
    m_fan   = (nstate != 0);
    m_state = nstate;
  endtask

  task automatic run_cycle(input logic rst, input logic [NF-1:0] c, input logic [NF-1:0] at,
                           input logic dc);
    reset = rst; call_req = c; at_floor = at; doors_closed = dc;
    model_step(rst, c, at, dc);
    @(posedge clk);
    @(negedge clk);
    check("state", state, m_state);
    check("cur_floor", cur_floor, m_floor);
    check("pending", pending, m_pend);
    check("motor_on", motor_on, m_motor);
    check("motor_direction", motor_direction, m_dir);
    check("fan_on", fan_on, m_fan);
    check("door_open", door_open, m_door);
    if (state == 3'd5 && prev_state != 3'd5) stops_q.push_back(cur_floor);
    if (door_open) door_cnt++;
    prev_state = state;
  endtask

  // Shaft plant: floors are a few clocks apart, sensor reads zero between floors.
  task automatic step_plant(input bit rnd, input logic [NF-1:0] extra);
    logic [NF-1:0] c, at;
    logic dc, rst;
    if (m_motor) begin
      travel++;
      if (travel >= hop) begin
        travel = 0;
        hop = $urandom_range(2, 4);
        if (m_dir) pos = (pos < NF - 1) ? pos + 1 : pos;
        else       pos = (pos > 0) ? pos - 1 : pos;
      end
    end else begin
      travel = 0;
    end
    at  = (travel == 0) ? (NF'(1) << pos) : '0;
    c   = extra;
    dc  = !m_door;
    rst = 1'b0;
    if (rnd) begin
      if ($urandom_range(0, 7) == 0)   c[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 39) == 0)  c = c | NF'($urandom);
      if ($urandom_range(0, 39) == 0)  at[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0)   dc = 1'b0;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    run_cycle(rst, c, at, dc);
  endtask

  task automatic do_reset();
    pos = 0; travel = 0;
    run_cycle(1'b1, '0, NF'(1), 1'b1);
    stops_q.delete();
    door_cnt = 0;
  endtask

  task automatic wait_for(input logic [2:0] target, input int budget, input string tag);
    for (int i = 0; i < budget && state != target; i++) step_plant(1'b0, '0);
    check(tag, state, target);
  endtask

  task automatic check_stops(input string tag);
    check({tag, "_count"}, stops_q.size(), exp_q.size());
    for (int i = 0; i < stops_q.size() && i < exp_q.size(); i++)
      check({tag, "_floor"}, stops_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_state = 3'd0;
    @(negedge clk);

    do_reset();
    check("rst_state", state, 0);
    check("rst_pending", pending, 0);
    check("rst_dir", motor_direction, 1);
    check("rst_fan", fan_on, 0);

    // Single call to floor 2 from floor 0.
    step_plant(1'b0, 8'h04);
    repeat (80) step_plant(1'b0, '0);
    exp_q.push_back(3'd2);
    check_stops("s1_stop");
    check("s1_door_cycles", door_cnt, DC);
    check("s1_idle", state, 0);
    check("s1_pending", pending, 0);

    // Floor 1 called after departure toward 3 and 6.
    do_reset();
    step_plant(1'b0, 8'h48);
    step_plant(1'b0, '0);
    step_plant(1'b0, 8'h02);
    repeat (150) step_plant(1'b0, '0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd3); exp_q.push_back(3'd6);
    check_stops("s2_stop");
    check("s2_idle", state, 0);

    // Doors open at 4 after travelling up, then 6 and 2 requested.
    do_reset();
    step_plant(1'b0, 8'h10);
    wait_for(3'd5, 60, "s3_reach_door");
    step_plant(1'b0, 8'h44);
    repeat (200) step_plant(1'b0, '0);
    exp_q.push_back(3'd4); exp_q.push_back(3'd6); exp_q.push_back(3'd2);
    check_stops("s3_stop");

    // Re-call of the floor the doors are open at extends the dwell.
    do_reset();
    step_plant(1'b0, 8'h01);
    repeat (5) step_plant(1'b0, '0);
    step_plant(1'b0, 8'h01);
    check("s4_pending_after_call", pending[0], 0);
    repeat (40) step_plant(1'b0, '0);
    check("s4_door_cycles", door_cnt, DC + 5);
    exp_q.push_back(3'd0);
    check_stops("s4_stop");

    // Multi-hot sensor while going up, then reset mid-descent.
    do_reset();
    step_plant(1'b0, 8'h50);
    step_plant(1'b0, '0);
    step_plant(1'b0, '0);
    check("s5_going_up", state, 2);
    run_cycle(1'b0, '0, 8'h12, 1'b1);
    check("s5_multihot_state", state, 2);
    check("s5_multihot_floor", cur_floor, 0);
    check("s5_multihot_door", door_open, 0);
    repeat (120) step_plant(1'b0, '0);
    exp_q.push_back(3'd4); exp_q.push_back(3'd6);
    check_stops("s5_stop");
    step_plant(1'b0, 8'h02);
    wait_for(3'd4, 40, "s5_going_down");
    run_cycle(1'b1, '0, NF'(1) << pos, 1'b1);
    check("s5_rst_state", state, 0);
    check("s5_rst_floor", cur_floor, 0);
    check("s5_rst_pending", pending, 0);
    check("s5_rst_motor", motor_on, 0);
    check("s5_rst_dir", motor_direction, 1);
    check("s5_rst_fan", fan_on, 0);
    check("s5_rst_door", door_open, 0);

    // Random traffic against the model.
    repeat (2500) step_plant(1'b1, '0);

    // Two-floor build: end stop at floor 1.
    tick();
    s2_reset = 1'b0; s2_call = 2'b10;
    tick();
    s2_call = 2'b00;
    repeat (2) tick();
    check("n2_going_up", s2_state, 2);
    s2_at = 2'b10;
    tick();
    check("n2_door_state", s2_state, 5);
    check("n2_floor", s2_floor, 1);
    check("n2_pending", s2_pend, 0);
    check("n2_door", s2_door, 1);

    // Sixteen-floor build: end stops at 15 and 0 with floor 5 still pending.
    s16_reset = 1'b0; s16_call = 16'h0020;
    tick();
    s16_call = '0;
    repeat (2) tick();
    check("n16_going_up", s16_state, 2);
    s16_at = 16'h8000;
    tick();
    check("n16_top_state", s16_state, 5);
    check("n16_top_floor", s16_floor, 15);
    check("n16_top_pending", s16_pend, 16'h0020);
    check("n16_top_motor", s16_motor, 0);
    for (int i = 0; i < 20 && s16_state != 3'd4; i++) tick();
    check("n16_going_down", s16_state, 4);
    s16_at = 16'h0001;
    tick();
    check("n16_bottom_state", s16_state, 5);
    check("n16_bottom_floor", s16_floor, 0);
    check("n16_bottom_pending", s16_pend, 16'h0020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
